// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or unsigned,
// with divide-by-zero and signed-overflow short cuts that skip the iteration.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dzp_q, dzp_d;
  logic             ovp_q, ovp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic             unused_trial_bit;

  assign mag_a = (signed_op && dividend[WIDTH-1]) ? (WIDTH'(0) - dividend) : dividend;
  assign mag_b = (signed_op && divisor[WIDTH-1])  ? (WIDTH'(0) - divisor)  : divisor;

  // Trial subtraction as A + ~B + 1, so the top bit is the ALU-style carry (1 = no borrow).
  assign shifted   = {rem_q, dvd_q[WIDTH-1]};
  assign trial     = {1'b0, shifted} + {1'b0, ~{1'b0, dsr_q}} + (WIDTH+2)'(1);
  assign no_borrow = trial[WIDTH+1];
  assign unused_trial_bit = trial[WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dzp_q   <= 1'b0;
      ovp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dzp_q   <= dzp_d;
      ovp_q   <= ovp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dzp_d   = dzp_q;
    ovp_d   = ovp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          cnt_d   = CW'(WIDTH-1);
          rem_d   = '0;
          dvd_d   = mag_a;
          dsr_d   = mag_b;
          qneg_d  = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d  = signed_op & dividend[WIDTH-1];
          dzp_d   = 1'b0;
          ovp_d   = 1'b0;
          state_d = CALC;
          // Special cases preload final results with no sign fix-up and go straight to FIX.
          if (divisor == '0) begin
            dvd_d   = '1;
            rem_d   = dividend;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            dzp_d   = 1'b1;
            state_d = FIX;
          end else if (signed_op && dividend == MIN_VAL && divisor == '1) begin
            dvd_d   = MIN_VAL;
            rem_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            ovp_d   = 1'b1;
            state_d = FIX;
          end
        end
      end
      CALC: begin
        dvd_d = {dvd_q[WIDTH-2:0], no_borrow};
        rem_d = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        quo_d   = qneg_q ? (WIDTH'(0) - dvd_q) : dvd_q;
        remo_d  = rneg_q ? (WIDTH'(0) - rem_q) : rem_q;
        dz_d    = dzp_q;
        ovf_d   = ovp_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = remo_q;
  assign div_zero  = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed WIDTH=8 scenarios plus
// randomized WIDTH=32 operations checked against a plain-arithmetic model.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic       start8, sop8, busy8, done8, dz8, ov8;
  logic [7:0] a8, b8, q8, r8;

  logic        start32, sop32, busy32, done32, dz32, ov32;
  logic [31:0] a32, b32, q32, r32;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .signed_op(sop8),
    .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_zero(dz8), .ovf(ov8)
  );

  seq_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .signed_op(sop32),
    .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
    .quotient(q32), .remainder(r32), .div_zero(dz32), .ovf(ov32)
  );

  // Division reference from arithmetic rules, not from the iteration.
  function automatic void ref32(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output logic ov);
    longint sa, sb;
    dz = 1'b0;
    ov = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; ov = 1'b1;
    end else if (s) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Starts an operation from a post-negedge position and returns just after the done negedge.
  task automatic do_op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cnt, output logic hold_ok);
    logic [7:0] q0, r0;
    q0 = q8; r0 = r8; hold_ok = 1'b1; lat = -1; busy_cnt = 0;
    sop8 = s; a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sop8 = 1'($urandom);
    if (busy8) busy_cnt++;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done8) begin lat = k; break; end
      if (busy8) busy_cnt++;
      if (q8 !== q0 || r8 !== r0) hold_ok = 1'b0;
    end
  endtask

  task automatic do_op32(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
    lat = -1;
    sop32 = s; a32 = a; b32 = b; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done32) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start8 = 1'b0; sop8 = 1'b0; a8 = '0; b8 = '0;
    start32 = 1'b0; sop32 = 1'b0; a32 = '0; b32 = '0;
    repeat (3) @(negedge clk);
    checks++; if ({busy8, done8, dz8, ov8} !== 4'b0) begin errors++; $display("FAIL reset_flags8 got %b want 0000", {busy8, done8, dz8, ov8}); end
    checks++; if ({q8, r8} !== 16'h0) begin errors++; $display("FAIL reset_results8 got %h want 0000", {q8, r8}); end
    checks++; if ({busy32, done32, dz32, ov32, q32, r32} !== 68'h0) begin errors++; $display("FAIL reset_dut32 got %h want 0", {busy32, done32, dz32, ov32, q32, r32}); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int lat, bc; logic hold;
    do_op8(1'b0, 8'd100, 8'd7, lat, bc, hold);
    checks++; if (lat !== 9) begin errors++; $display("FAIL unsigned_latency got %0d want 9", lat); end
    checks++; if (q8 !== 8'd14 || r8 !== 8'd2) begin errors++; $display("FAIL unsigned_result got q=%0d r=%0d want q=14 r=2", q8, r8); end
    checks++; if (dz8 !== 1'b0 || ov8 !== 1'b0) begin errors++; $display("FAIL unsigned_flags got dz=%b ov=%b want 0 0", dz8, ov8); end
    checks++; if (bc !== 9 || busy8 !== 1'b0) begin errors++; $display("FAIL unsigned_busy got cycles=%0d busy_at_done=%b want 9 0", bc, busy8); end
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL unsigned_hold got %b want 1", hold); end
  endtask

  task automatic test_signed();
    int lat, bc; logic hold;
    do_op8(1'b1, 8'hF9, 8'h02, lat, bc, hold);
    checks++; if (q8 !== 8'hFD || r8 !== 8'hFF) begin errors++; $display("FAIL signed_neg_dividend got q=%h r=%h want fd ff", q8, r8); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL signed_latency got %0d want 9", lat); end
    do_op8(1'b1, 8'h07, 8'hFE, lat, bc, hold);
    checks++; if (q8 !== 8'hFD || r8 !== 8'h01) begin errors++; $display("FAIL signed_neg_divisor got q=%h r=%h want fd 01", q8, r8); end
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL signed_hold got %b want 1", hold); end
  endtask

  task automatic test_div_zero();
    int lat, bc; logic hold;
    do_op8(1'b0, 8'h55, 8'h00, lat, bc, hold);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
    checks++; if (q8 !== 8'hFF || r8 !== 8'h55 || dz8 !== 1'b1 || ov8 !== 1'b0) begin errors++; $display("FAIL dz_result got q=%h r=%h dz=%b ov=%b want ff 55 1 0", q8, r8, dz8, ov8); end
    repeat (4) @(negedge clk);
    checks++; if (dz8 !== 1'b1 || q8 !== 8'hFF) begin errors++; $display("FAIL dz_hold got dz=%b q=%h want 1 ff", dz8, q8); end
    do_op8(1'b1, 8'hAB, 8'h00, lat, bc, hold);
    checks++; if (q8 !== 8'hFF || r8 !== 8'hAB || dz8 !== 1'b1 || lat !== 1) begin errors++; $display("FAIL dz_signed got q=%h r=%h dz=%b lat=%0d want ff ab 1 1", q8, r8, dz8, lat); end
    do_op8(1'b0, 8'd20, 8'd3, lat, bc, hold);
    checks++; if (q8 !== 8'd6 || r8 !== 8'd2 || dz8 !== 1'b0) begin errors++; $display("FAIL dz_cleared got q=%0d r=%0d dz=%b want 6 2 0", q8, r8, dz8); end
  endtask

  task automatic test_overflow();
    int lat, bc; logic hold;
    do_op8(1'b1, 8'h80, 8'hFF, lat, bc, hold);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_latency got %0d want 1", lat); end
    checks++; if (q8 !== 8'h80 || r8 !== 8'h00 || ov8 !== 1'b1 || dz8 !== 1'b0) begin errors++; $display("FAIL ovf_result got q=%h r=%h ov=%b dz=%b want 80 00 1 0", q8, r8, ov8, dz8); end
    do_op8(1'b0, 8'h80, 8'hFF, lat, bc, hold);
    checks++; if (q8 !== 8'h00 || r8 !== 8'h80 || ov8 !== 1'b0 || lat !== 9) begin errors++; $display("FAIL ovf_unsigned got q=%h r=%h ov=%b lat=%0d want 00 80 0 9", q8, r8, ov8, lat); end
  endtask

  task automatic test_busy_start();
    int dones, lat;
    dones = 0; lat = -1;
    sop8 = 1'b0; a8 = 8'd100; b8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start8 = (k == 2);
      if (k == 2) begin a8 = 8'd50; b8 = 8'd5; end
      if (done8) begin dones++; if (lat < 0) lat = k; end
    end
    start8 = 1'b0;
    checks++; if (dones !== 1 || lat !== 9) begin errors++; $display("FAIL busy_start got dones=%0d lat=%0d want 1 9", dones, lat); end
    checks++; if (q8 !== 8'd14 || r8 !== 8'd2) begin errors++; $display("FAIL busy_start_result got q=%0d r=%0d want 14 2", q8, r8); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic hold;
    do_op8(1'b0, 8'd200, 8'd9, lat, bc, hold);
    checks++; if (q8 !== 8'd22 || r8 !== 8'd2) begin errors++; $display("FAIL b2b_first got q=%0d r=%0d want 22 2", q8, r8); end
    do_op8(1'b1, 8'h9C, 8'h0B, lat, bc, hold);
    checks++; if (lat !== 9 || q8 !== 8'hF7 || r8 !== 8'hFF) begin errors++; $display("FAIL b2b_second got lat=%0d q=%h r=%h want 9 f7 ff", lat, q8, r8); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, dones; logic hold;
    dones = 0;
    sop8 = 1'b0; a8 = 8'd100; b8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if ({busy8, done8, dz8, ov8, q8, r8} !== 20'h0) begin errors++; $display("FAIL reset_mid got %h want 0", {busy8, done8, dz8, ov8, q8, r8}); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL reset_mid_no_done got %0d want 0", dones); end
    do_op8(1'b0, 8'd100, 8'd7, lat, bc, hold);
    checks++; if (lat !== 9 || q8 !== 8'd14 || r8 !== 8'd2) begin errors++; $display("FAIL reset_mid_restart got lat=%0d q=%0d r=%0d want 9 14 2", lat, q8, r8); end
  endtask

  task automatic test_random();
    logic [31:0] corners [5];
    logic [31:0] a, b, eq, er, recon;
    logic s, edz, eov;
    int lat, elat;
    corners[0] = 32'h8000_0000; corners[1] = 32'h7FFF_FFFF; corners[2] = 32'h0;
    corners[3] = 32'h1; corners[4] = 32'hFFFF_FFFF;
    for (int i = 0; i < 1500; i++) begin
      s = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 3))
        0: b = corners[$urandom_range(0, 4)];
        1: b = 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      if (i % 50 == 0) begin s = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      ref32(s, a, b, eq, er, edz, eov);
      elat = (edz || eov) ? 1 : 33;
      do_op32(s, a, b, lat);
      recon = q32 * b + r32;
      checks++; if (q32 !== eq || r32 !== er) begin errors++; $display("FAIL rand_result s=%b a=%h b=%h got q=%h r=%h want q=%h r=%h", s, a, b, q32, r32, eq, er); end
      checks++; if (dz32 !== edz || ov32 !== eov) begin errors++; $display("FAIL rand_flags s=%b a=%h b=%h got dz=%b ov=%b want %b %b", s, a, b, dz32, ov32, edz, eov); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL rand_latency a=%h b=%h got %0d want %0d", a, b, lat, elat); end
      checks++; if (recon !== a) begin errors++; $display("FAIL rand_invariant a=%h b=%h got q*b+r=%h want %h", a, b, recon, a); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
